// File: rtl/sort_pkg.sv
// Shared definitions for the sequential sort controller: FSM state encoding
// and the width rule for the pass counter.
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pass counter width: wide enough to hold N-1 passes (N >= 2).
  function automatic int pass_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/single_pass_sorter.sv
// One combinational bubble pass over an N-element window. Element 0 sits in
// the MSB lane; the largest element is carried toward the LSB lane. Equal
// neighbours are never swapped, so repeated passes are deterministic.
module single_pass_sorter #(
  parameter int N          = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic [N*DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] lane [N];
  logic [DATA_WIDTH-1:0] tmp;

  // Unpack lanes, compare-and-swap neighbours from lane 0 upward, repack.
  always_comb begin
    tmp = '0;
    for (int i = 0; i < N; i++) begin
      lane[i] = in_data[(N-1-i)*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < N-1; i++) begin
      if (lane[i] > lane[i+1]) begin
        tmp       = lane[i];
        lane[i]   = lane[i+1];
        lane[i+1] = tmp;
      end
    end
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data[(N-1-i)*DATA_WIDTH +: DATA_WIDTH] = lane[i];
    end
  end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Sequential sort controller: accepts a window, runs one bubble pass per
// clock through a single pass network, then presents the sorted window and
// its median until downstream takes it.
// Optional feature macro: SORT_EARLY_EXIT_EN (stop as soon as a pass makes
// no swap; the N-1 pass limit still applies).
module sort_seq_ctrl
  import sort_pkg::*;
#(
  parameter int N          = 5,
  parameter int DATA_WIDTH = 8,
  parameter int PASS_W     = sort_pkg::pass_width(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0]   out_median,
  output logic [PASS_W-1:0]       out_passes,
  output logic                    busy
);

  localparam int MED = (N - 1) / 2;

  state_t                  state;
  state_t                  next_state;
  logic [N*DATA_WIDTH-1:0] work;
  logic [N*DATA_WIDTH-1:0] pass_out;
  logic [PASS_W-1:0]       pass_cnt;
  logic                    sort_done;

  single_pass_sorter #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pass (
    .in_data  (work),
    .out_data (pass_out)
  );

  // The pass being performed this cycle is the last one for the window.
  always_comb begin
    sort_done = (pass_cnt == PASS_W'(N - 2));
`ifdef SORT_EARLY_EXIT_EN
    if (pass_out == work) begin
      sort_done = 1'b1;
    end
`else
`endif
  end

  // State register; reset abandons any window in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = SORT;
      SORT:    if (sort_done) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake and status outputs decoded straight from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SORT);
    out_valid = (state == DONE);
  end

  // Working register, pass counter, and result registers that only move on
  // the edge entering DONE so the result stays stable while it is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= '0;
      pass_cnt   <= '0;
      out_data   <= '0;
      out_median <= '0;
      out_passes <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            pass_cnt <= '0;
          end
        end
        SORT: begin
          work     <= pass_out;
          pass_cnt <= pass_cnt + PASS_W'(1);
          if (sort_done) begin
            out_data   <= pass_out;
            out_median <= pass_out[(N-1-MED)*DATA_WIDTH +: DATA_WIDTH];
            out_passes <= pass_cnt + PASS_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench for sort_seq_ctrl (N=5, DATA_WIDTH=8). Expected
// results are pushed to a scoreboard queue when a window is accepted and
// popped when the controller offers its result.
module tb_sort_seq_ctrl;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int PW = $clog2(N);
  localparam int NW = N * W;

  typedef logic [W-1:0] win_t [N];

  typedef struct {
    logic [NW-1:0] data;
    logic [W-1:0]  median;
    int            passes;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] out_data;
  logic [W-1:0]  out_median;
  logic [PW-1:0] out_passes;
  logic          busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  sort_seq_ctrl #(.N(N), .DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_median (out_median),
    .out_passes (out_passes),
    .busy       (busy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something never terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NW-1:0] packWin(input win_t e);
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[(N-1-i)*W +: W] = e[i];
    return r;
  endfunction

  // Reference result: selection sort for the data; the pass count comes from
  // the largest number of greater elements sitting ahead of any element,
  // which is how far that element must travel toward lane 0.
  function automatic exp_t buildExpected(input win_t e);
    exp_t      x;
    win_t      s;
    logic [W-1:0] t;
    int        max_left;
    int        cnt;
    int        m;
    s = e;
    for (int i = 0; i < N; i++) begin
      m = i;
      for (int j = i + 1; j < N; j++) if (s[j] < s[m]) m = j;
      t = s[i]; s[i] = s[m]; s[m] = t;
    end
    max_left = 0;
    for (int i = 0; i < N; i++) begin
      cnt = 0;
      for (int j = 0; j < i; j++) if (e[j] > e[i]) cnt++;
      if (cnt > max_left) max_left = cnt;
    end
    x.data   = packWin(s);
    x.median = s[(N-1)/2];
`ifdef SORT_EARLY_EXIT_EN
    x.passes = (max_left + 1 < N - 1) ? max_left + 1 : N - 1;
`else
    x.passes = N - 1;
`endif
    return x;
  endfunction

  // Drive a window and return #1 after the accepting edge.
  task automatic applyStimulus(input win_t e);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = packWin(e);
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(buildExpected(e));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, check latency and contents against the scoreboard.
  task automatic collectResult(input string tag, output exp_t x);
    int cycles;
    cycles = 0;
    x.data = '0; x.median = '0; x.passes = 0;
    while (!out_valid && cycles < 30) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!out_valid || sb.size() == 0) begin
      checkOutput({tag, "_timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    x = sb.pop_front();
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(x.passes));
    checkOutput({tag, "_data"},    64'(out_data), 64'(x.data));
    checkOutput({tag, "_median"},  64'(out_median), 64'(x.median));
    checkOutput({tag, "_passes"},  64'(out_passes), 64'(x.passes));
    checkOutput({tag, "_inready"}, 64'(in_ready), 64'd0);
  endtask

  task automatic runWindow(input string tag, input win_t e);
    exp_t x;
    applyStimulus(e);
    collectResult(tag, x);
    @(posedge clk);
    #1;
    checkOutput({tag, "_release"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    win_t w;
    win_t w2;
    exp_t xa;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    checkOutput("rst_inready",  64'(in_ready), 64'd1);
    checkOutput("rst_outvalid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy",     64'(busy), 64'd0);
    checkOutput("rst_data",     64'(out_data), 64'd0);
    checkOutput("rst_passes",   64'(out_passes), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    w = '{8'd5, 8'd1, 8'd4, 8'd2, 8'd8}; runWindow("basic", w);
    w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5}; runWindow("sorted", w);
    w = '{8'd9, 8'd7, 8'd5, 8'd3, 8'd1}; runWindow("reverse", w);
    w = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd3}; runWindow("dups", w);
    w = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd128}; runWindow("extremes", w);

    // Backpressure: hold the result while a new window waits at the input.
    out_ready = 1'b0;
    w  = '{8'd6, 8'd2, 8'd9, 8'd1, 8'd4};
    w2 = '{8'd7, 8'd7, 8'd0, 8'd3, 8'd1};
    applyStimulus(w);
    collectResult("bp", xa);
    in_valid = 1'b1;
    in_data  = packWin(w2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_valid",   64'(out_valid), 64'd1);
      checkOutput("bp_hold_data",    64'(out_data), 64'(xa.data));
      checkOutput("bp_hold_median",  64'(out_median), 64'(xa.median));
      checkOutput("bp_hold_passes",  64'(out_passes), 64'(xa.passes));
      checkOutput("bp_hold_inready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_after_inready", 64'(in_ready), 64'd1);
    checkOutput("bp_after_valid",   64'(out_valid), 64'd0);
    sb.push_back(buildExpected(w2));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collectResult("bp_next", xa);
    @(posedge clk);
    #1;

    // Reset in the middle of sorting.
    w = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    applyStimulus(w);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid",   64'(out_valid), 64'd0);
    checkOutput("mid_rst_busy",    64'(busy), 64'd0);
    checkOutput("mid_rst_inready", 64'(in_ready), 64'd1);
    checkOutput("mid_rst_data",    64'(out_data), 64'd0);
    checkOutput("mid_rst_median",  64'(out_median), 64'd0);
    checkOutput("mid_rst_passes",  64'(out_passes), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    w = '{8'd2, 8'd0, 8'd1, 8'd0, 8'd2}; runWindow("fresh", w);

    // A few random windows with a small value range to provoke duplicates.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) w[i] = W'($urandom_range(0, 15));
      runWindow("rand", w);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
